// File: rtl/pipelined_cla_adder_pkg.sv
// Shared types for the pipelined carry-lookahead adder: operation codes,
// per-stage control word and the 4-bit lookahead group used to build each chunk.
package pipelined_cla_adder_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_ADC = 2'b10,
        OP_SBB = 2'b11
    } op_e;

    // Control half of a stage register; operand/sum bits live beside it
    // because their width shrinks/grows from stage to stage.
    typedef struct packed {
        logic valid;
        logic carry;
        logic zero;
    } stage_ctrl_t;

    typedef struct packed {
        logic [3:0] sum;
        logic       prop;
        logic       gen;
    } cla4_t;

    function automatic cla4_t cla4(input logic [3:0] a, input logic [3:0] b, input logic cin);
        cla4_t      res;
        logic [3:0] p;
        logic [3:0] g;
        logic [3:0] c;
        p    = a ^ b;
        g    = a & b;
        c[0] = cin;
        c[1] = g[0] | (p[0] & cin);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
        res.sum  = p ^ c;
        res.prop = &p;
        res.gen  = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
        return res;
    endfunction

endpackage

// File: rtl/pipelined_cla_adder_cla.sv
// CHUNK-bit carry-lookahead adder: 4-bit lookahead groups joined by a
// group-level generate/propagate carry chain.
module cla_chunk_adder
    import pipelined_cla_adder_pkg::*;
#(
    parameter int CHUNK = 16
) (
    input  logic [CHUNK-1:0] i_a,
    input  logic [CHUNK-1:0] i_b,
    input  logic             i_cin,
    output logic [CHUNK-1:0] o_sum,
    output logic             o_cout,
    output logic             o_zero
);
    localparam int NGRP = CHUNK / 4;

    if ((CHUNK % 4) != 0 || CHUNK < 4) begin : gen_bad_chunk
        $error("cla_chunk_adder: CHUNK must be a positive multiple of 4");
    end

    logic [NGRP:0]    w_gc;
    logic [CHUNK-1:0] w_sum;

    // NOTE: every variable gets a default before the loop, so no path through
    // this block can leave a value held and infer a latch.
    always_comb begin
        cla4_t v_grp;
        v_grp   = '0;
        w_sum   = '0;
        w_gc    = '0;
        w_gc[0] = i_cin;
        for (int j = 0; j < NGRP; j++) begin
            v_grp            = cla4(i_a[4*j +: 4], i_b[4*j +: 4], w_gc[j]);
            w_sum[4*j +: 4]  = v_grp.sum;
            w_gc[j+1]        = v_grp.gen | (v_grp.prop & w_gc[j]);
        end
    end

    assign o_sum  = w_sum;
    assign o_cout = w_gc[NGRP];
    assign o_zero = ~|w_sum;

endmodule

// File: rtl/pipelined_cla_adder.sv
// WIDTH-bit ADD/SUB/ADC/SBB unit resolving CHUNK bits per pipeline stage,
// with a single global advance for valid/ready flow control.
module pipelined_cla_adder
    import pipelined_cla_adder_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [1:0]       in_op,
    input  logic             in_cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf,
    output logic             out_zero,
    output logic             out_neg
);
    localparam int NSTG = WIDTH / CHUNK;

    if ((WIDTH % CHUNK) != 0 || WIDTH < CHUNK || (CHUNK % 4) != 0) begin : gen_bad_cfg
        $error("pipelined_cla_adder: WIDTH must be a multiple of CHUNK and CHUNK a multiple of 4");
    end

    logic             w_advance;
    logic [WIDTH-1:0] w_b_eff;
    logic             w_c0;

    assign w_advance = !out_valid || out_ready;
    assign in_ready  = w_advance;

    always_comb begin
        w_b_eff = in_b;
        w_c0    = 1'b0;
        case (op_e'(in_op))
            OP_ADD: ;
            OP_SUB: begin w_b_eff = ~in_b; w_c0 = 1'b1;   end
            OP_ADC: begin                  w_c0 = in_cin; end
            OP_SBB: begin w_b_eff = ~in_b; w_c0 = in_cin; end
            default: ;
        endcase
    end

    genvar k;
    for (k = 0; k < NSTG; k++) begin : gen_stg
        // Register layout: {unresolved A, unresolved B', resolved sum}; the
        // last stage keeps only the finished sum.
        localparam int REM_IN = WIDTH - k*CHUNK;
        localparam int DW     = (k == NSTG-1) ? WIDTH : 2*WIDTH - (k+1)*CHUNK;

        logic [REM_IN-1:0]       w_a_hi;
        logic [REM_IN-1:0]       w_b_hi;
        logic                    w_cin;
        logic                    w_zero_in;
        logic                    w_valid_in;
        logic [CHUNK-1:0]        w_chunk_sum;
        logic                    w_chunk_cout;
        logic                    w_chunk_zero;
        logic [(k+1)*CHUNK-1:0]  w_sum_acc;
        logic [DW-1:0]           w_data_nxt;
        stage_ctrl_t             r_ctrl;
        logic [DW-1:0]           r_data;

        if (k == 0) begin : gen_src
            assign w_a_hi     = in_a;
            assign w_b_hi     = w_b_eff;
            assign w_cin      = w_c0;
            assign w_zero_in  = 1'b1;
            assign w_valid_in = in_valid;
            assign w_sum_acc  = w_chunk_sum;
        end else begin : gen_src
            localparam int PW = 2*WIDTH - k*CHUNK;
            assign w_a_hi     = gen_stg[k-1].r_data[PW-1 -: REM_IN];
            assign w_b_hi     = gen_stg[k-1].r_data[PW-1-REM_IN -: REM_IN];
            assign w_cin      = gen_stg[k-1].r_ctrl.carry;
            assign w_zero_in  = gen_stg[k-1].r_ctrl.zero;
            assign w_valid_in = gen_stg[k-1].r_ctrl.valid;
            assign w_sum_acc  = {w_chunk_sum, gen_stg[k-1].r_data[k*CHUNK-1:0]};
        end

        cla_chunk_adder #(.CHUNK(CHUNK)) u_cla (
            .i_a    (w_a_hi[CHUNK-1:0]),
            .i_b    (w_b_hi[CHUNK-1:0]),
            .i_cin  (w_cin),
            .o_sum  (w_chunk_sum),
            .o_cout (w_chunk_cout),
            .o_zero (w_chunk_zero)
        );

        if (k == NSTG-1) begin : gen_last
            logic w_ovf;
            logic r_ovf;
            assign w_data_nxt = w_sum_acc;
            assign w_ovf = (w_a_hi[CHUNK-1] == w_b_hi[CHUNK-1]) &&
                           (w_chunk_sum[CHUNK-1] != w_a_hi[CHUNK-1]);
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_ovf <= 1'b0;
                end else if (w_advance && w_valid_in) begin
                    r_ovf <= w_ovf;
                end
            end
        end else begin : gen_mid
            assign w_data_nxt = {w_a_hi[REM_IN-1:CHUNK], w_b_hi[REM_IN-1:CHUNK], w_sum_acc};
        end

        // NOTE: non-blocking updates, so every stage samples its
        // predecessor's pre-edge value and the whole pipe shifts as one.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_ctrl <= '0;
                r_data <= '0;
            end else if (w_advance) begin
                r_ctrl.valid <= w_valid_in;
                if (w_valid_in) begin
                    r_ctrl.carry <= w_chunk_cout;
                    r_ctrl.zero  <= w_zero_in & w_chunk_zero;
                    r_data       <= w_data_nxt;
                end
            end
        end
    end

    assign out_valid = gen_stg[NSTG-1].r_ctrl.valid;
    assign out_sum   = gen_stg[NSTG-1].r_data;
    assign out_cout  = gen_stg[NSTG-1].r_ctrl.carry;
    assign out_zero  = gen_stg[NSTG-1].r_ctrl.zero;
    assign out_ovf   = gen_stg[NSTG-1].gen_last.r_ovf;
    assign out_neg   = out_sum[WIDTH-1];

endmodule
